// File: rtl/rail_power_sequencer_if.sv
// Board-side bundle for rail_power_sequencer.
// master: the board / host (drives the enable request and the raw power-good pins).
// slave : the sequencer (drives regulator enables and status).
interface rail_power_sequencer_if #(
    parameter int NUM_RAILS = 4
);
    logic                 enable;
    logic [NUM_RAILS-1:0] pg;
    logic [NUM_RAILS-1:0] en;
    logic                 all_good;
    logic                 fault;
    logic [3:0]           fault_rail;
    logic [2:0]           state;

    modport master (
        output enable,
        output pg,
        input  en,
        input  all_good,
        input  fault,
        input  fault_rail,
        input  state
    );

    modport slave (
        input  enable,
        input  pg,
        output en,
        output all_good,
        output fault,
        output fault_rail,
        output state
    );
endinterface

// File: rtl/rail_power_sequencer.sv
// N-rail power sequencer: brings regulator enables up in index order, each
// rail gated by its power-good plus a settle hold, supervises power-good while
// running, and brings rails down in reverse order. Any supervision failure
// drops every rail at once and parks in FAULT for a cooldown.
//
// Optional build macro PWRSEQ_RETRY_EN: after a fault's cooldown, with enable
// still high, retry the whole ramp up to RETRY_MAX times before LOCKOUT.
// Without it, a fault with enable held high goes straight to LOCKOUT.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | all rails off, waiting for enable
// UP_WAIT   | en[idx] asserted, waiting for pg_s[idx] (timeout = fault)
// UP_SETTLE | pg_s[idx] seen, holding before the next rail
// RUN       | all rails up, all_good=1, supervising every pg_s
// DN_WAIT   | en[idx] cleared, waiting for pg_s[idx] low (timeout is benign)
// DN_SETTLE | holding before the next lower rail is released
// FAULT     | all rails off, cooldown timer running
// LOCKOUT   | all rails off until enable is withdrawn
module rail_power_sequencer #(
    parameter int NUM_RAILS       = 4,
    parameter int CNT_W           = 16,
    parameter int TIMEOUT_CYCLES  = 40000,
    parameter int SETTLE_CYCLES   = 6400,
    parameter int COOLDOWN_CYCLES = 40000,
    parameter int RETRY_MAX       = 2
) (
    input  logic                  sysclk,
    input  logic                  reset_INV,
    rail_power_sequencer_if.slave bus
);

    localparam int               IDX_W       = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_RAILS - 1);
    localparam logic [63:0]      CNT_MAX     = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] TIMEOUT_LD  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] COOLDOWN_LD = CNT_W'(COOLDOWN_CYCLES);

    // Parameter sanity: refuse to elaborate an unusable configuration.
    generate
        if (NUM_RAILS < 1 || NUM_RAILS > 16) begin : g_bad_num_rails
            $error("rail_power_sequencer: NUM_RAILS must be in 1..16");
        end
        if (CNT_W < 1 || CNT_W > 63 ||
            64'(TIMEOUT_CYCLES)  > CNT_MAX ||
            64'(SETTLE_CYCLES)   > CNT_MAX ||
            64'(COOLDOWN_CYCLES) > CNT_MAX) begin : g_bad_cnt_w
            $error("rail_power_sequencer: CNT_W too narrow for a *_CYCLES value");
        end
        if (RETRY_MAX < 0) begin : g_bad_retry_max
            $error("rail_power_sequencer: RETRY_MAX must be non-negative");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        UP_WAIT   = 3'd1,
        UP_SETTLE = 3'd2,
        RUN       = 3'd3,
        DN_WAIT   = 3'd4,
        DN_SETTLE = 3'd5,
        FAULT     = 3'd6,
        LOCKOUT   = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [NUM_RAILS-1:0] en_q, en_d;
    logic [3:0]           fault_rail_q, fault_rail_d;
    logic [NUM_RAILS-1:0] pg_meta_q, pg_s_q;

`ifdef PWRSEQ_RETRY_EN
    localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RETRY_W-1:0] retries_q, retries_d;
`endif

    logic             up_bad, run_bad;
    logic [3:0]       low_up, low_run;
    logic [IDX_W-1:0] idx_inc, idx_dec;
    logic             timer_zero;

    assign idx_inc    = idx_q + 1'b1;
    assign idx_dec    = idx_q - 1'b1;
    assign timer_zero = (timer_q == '0);

    // Two-flop synchronizer for the asynchronous board power-good pins.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            pg_meta_q <= '0;
            pg_s_q    <= '0;
        end else begin
            pg_meta_q <= bus.pg;
            pg_s_q    <= pg_meta_q;
        end
    end

    // Lowest rail with power-good low: over all rails (RUN) and over rails 0..idx (UP_SETTLE).
    always_comb begin
        up_bad  = 1'b0;
        run_bad = 1'b0;
        low_up  = '0;
        low_run = '0;
        for (int k = NUM_RAILS - 1; k >= 0; k--) begin
            if (!pg_s_q[k]) begin
                run_bad = 1'b1;
                low_run = 4'(k);
                if (k <= int'(idx_q)) begin
                    up_bad = 1'b1;
                    low_up = 4'(k);
                end
            end
        end
    end

    // State, index, timer, enables and fault record.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            en_q         <= '0;
            fault_rail_q <= '0;
`ifdef PWRSEQ_RETRY_EN
            retries_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            en_q         <= en_d;
            fault_rail_q <= fault_rail_d;
`ifdef PWRSEQ_RETRY_EN
            retries_q    <= retries_d;
`endif
        end
    end

    // Next-state logic; the timer free-runs down to 0 and is reloaded on each state entry.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        en_d         = en_q;
        fault_rail_d = fault_rail_q;
        timer_d      = timer_zero ? '0 : timer_q - 1'b1;
`ifdef PWRSEQ_RETRY_EN
        retries_d    = bus.enable ? retries_q : '0;
`endif

        case (state_q)
            IDLE: begin
                en_d = '0;
                if (bus.enable) begin
                    idx_d   = '0;
                    en_d[0] = 1'b1;
                    timer_d = TIMEOUT_LD;
                    state_d = UP_WAIT;
                end
            end

            UP_WAIT: begin
                if (!pg_s_q[idx_q] && timer_zero) begin
                    en_d         = '0;
                    fault_rail_d = 4'(idx_q);
                    timer_d      = COOLDOWN_LD;
                    state_d      = FAULT;
                end else if (!bus.enable) begin
                    en_d[idx_q] = 1'b0;
                    timer_d     = TIMEOUT_LD;
                    state_d     = DN_WAIT;
                end else if (pg_s_q[idx_q]) begin
                    timer_d = SETTLE_LD;
                    state_d = UP_SETTLE;
                end
            end

            UP_SETTLE: begin
                if (up_bad) begin
                    en_d         = '0;
                    fault_rail_d = low_up;
                    timer_d      = COOLDOWN_LD;
                    state_d      = FAULT;
                end else if (!bus.enable) begin
                    en_d[idx_q] = 1'b0;
                    timer_d     = TIMEOUT_LD;
                    state_d     = DN_WAIT;
                end else if (timer_zero) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
`ifdef PWRSEQ_RETRY_EN
                        retries_d = '0;
`endif
                    end else begin
                        idx_d         = idx_inc;
                        en_d[idx_inc] = 1'b1;
                        timer_d       = TIMEOUT_LD;
                        state_d       = UP_WAIT;
                    end
                end
            end

            RUN: begin
                if (run_bad) begin
                    en_d         = '0;
                    fault_rail_d = low_run;
                    timer_d      = COOLDOWN_LD;
                    state_d      = FAULT;
                end else if (!bus.enable) begin
                    idx_d          = LAST_IDX;
                    en_d[LAST_IDX] = 1'b0;
                    timer_d        = TIMEOUT_LD;
                    state_d        = DN_WAIT;
                end
            end

            // A rail that never reports low is released anyway once the timer runs out.
            DN_WAIT: begin
                if (!pg_s_q[idx_q] || timer_zero) begin
                    timer_d = SETTLE_LD;
                    state_d = DN_SETTLE;
                end
            end

            DN_SETTLE: begin
                if (timer_zero) begin
                    if (idx_q == '0) begin
                        en_d    = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d         = idx_dec;
                        en_d[idx_dec] = 1'b0;
                        timer_d       = TIMEOUT_LD;
                        state_d       = DN_WAIT;
                    end
                end
            end

            FAULT: begin
                en_d = '0;
                if (timer_zero) begin
                    if (!bus.enable) begin
                        state_d = IDLE;
`ifdef PWRSEQ_RETRY_EN
                    end else if (retries_q < RETRY_W'(RETRY_MAX)) begin
                        retries_d = retries_q + 1'b1;
                        idx_d     = '0;
                        en_d[0]   = 1'b1;
                        timer_d   = TIMEOUT_LD;
                        state_d   = UP_WAIT;
`endif
                    end else begin
                        state_d = LOCKOUT;
                    end
                end
            end

            LOCKOUT: begin
                en_d = '0;
                if (!bus.enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                en_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.en         = en_q;
    assign bus.all_good   = (state_q == RUN);
    assign bus.fault      = (state_q == FAULT) || (state_q == LOCKOUT);
    assign bus.fault_rail = fault_rail_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_rail_power_sequencer.sv
// Directed bench for rail_power_sequencer with 3 rails and short timers.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rail_power_sequencer;

    localparam int NR       = 3;
    localparam int TIMEOUT  = 20;
    localparam int SETTLE   = 4;
    localparam int COOLDOWN = 10;
    localparam int RETRYMAX = 2;
`ifdef PWRSEQ_RETRY_EN
    localparam int ATTEMPTS = 1 + RETRYMAX;
`else
    localparam int ATTEMPTS = 1;
`endif
    // Falling-edge pg drive -> next en step: sampling edge + 2 sync + (SETTLE+1) hold.
    localparam int STEP_LAT = 1 + 2 + (SETTLE + 1);

    logic sysclk;
    logic reset_INV;
    int   nvec;
    int   nerr;

    rail_power_sequencer_if #(.NUM_RAILS(NR)) pwr ();

    rail_power_sequencer #(
        .NUM_RAILS      (NR),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SETTLE_CYCLES  (SETTLE),
        .COOLDOWN_CYCLES(COOLDOWN),
        .RETRY_MAX      (RETRYMAX)
    ) dut (
        .sysclk   (sysclk),
        .reset_INV(reset_INV),
        .bus      (pwr)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic wait_en(input string tag, input logic [NR-1:0] exp, input int budget, output int w);
        w = 0;
        while (pwr.en !== exp && w < budget) begin
            @(negedge sysclk);
            w++;
        end
        chk({tag, " en reached"}, 32'(pwr.en), 32'(exp));
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int budget, output int w);
        w = 0;
        while (pwr.state !== exp && w < budget) begin
            @(negedge sysclk);
            w++;
        end
        chk({tag, " state reached"}, 32'(pwr.state), 32'(exp));
    endtask

    // pg echoes each new enable 5 cycles later; every en step after the first is timed.
    task automatic ramp(input string tag, input int nrails);
        int w;
        logic [NR-1:0] m;
        for (int k = 0; k < nrails; k++) begin
            m = NR'((1 << (k + 1)) - 1);
            wait_en($sformatf("%s rail%0d", tag, k), m, 60, w);
            if (k > 0) chk($sformatf("%s rail%0d step latency", tag, k), 32'(w), 32'(STEP_LAT));
            tick(5);
            pwr.pg[k] = 1'b1;
        end
    endtask

    initial begin
        int w;
        nvec = 0;
        nerr = 0;
        reset_INV  = 1'b0;
        pwr.enable = 1'b0;
        pwr.pg     = '0;

        // Reset values
        tick(1);
        chk("rst en", 32'(pwr.en), 32'h0);
        chk("rst all_good", 32'(pwr.all_good), 32'h0);
        chk("rst fault", 32'(pwr.fault), 32'h0);
        chk("rst fault_rail", 32'(pwr.fault_rail), 32'h0);
        chk("rst state", 32'(pwr.state), 32'h0);
        reset_INV = 1'b1;
        tick(2);

        // 1: happy power-up
        pwr.enable = 1'b1;
        ramp("up", NR);
        wait_state("up run", 3'd3, 40, w);
        chk("up run latency", 32'(w), 32'(STEP_LAT));
        chk("up all_good", 32'(pwr.all_good), 32'h1);
        chk("up en", 32'(pwr.en), 32'h7);

        // 2: ordered power-down, rail 2 held high until its timeout
        pwr.enable = 1'b0;
        wait_en("dn rail2 off", 3'b011, 5, w);
        chk("dn rail2 latency", 32'(w), 32'd1);
        chk("dn state dn_wait", 32'(pwr.state), 32'd4);
        wait_state("dn timeout", 3'd5, 40, w);
        chk("dn timeout latency", 32'(w), 32'(TIMEOUT + 1));
        wait_en("dn rail1 off", 3'b001, 20, w);
        chk("dn settle latency", 32'(w), 32'(SETTLE + 1));
        pwr.pg = 3'b001;
        wait_en("dn rail0 off", 3'b000, 40, w);
        chk("dn pg-low latency", 32'(w), 32'(STEP_LAT));
        pwr.pg = 3'b000;
        wait_state("dn idle", 3'd0, 40, w);
        chk("dn idle latency", 32'(w), 32'(STEP_LAT));
        chk("dn fault", 32'(pwr.fault), 32'h0);

        // 3: rail 1 never reports power-good
        tick(2);
        pwr.enable = 1'b1;
        ramp("to", 1);
        wait_en("to rail1 on", 3'b011, 40, w);
        chk("to rail1 latency", 32'(w), 32'(STEP_LAT));
        wait_state("to fault", 3'd6, 60, w);
        chk("to fault latency", 32'(w), 32'(TIMEOUT + 1));
        chk("to en", 32'(pwr.en), 32'h0);
        chk("to fault", 32'(pwr.fault), 32'h1);
        chk("to fault_rail", 32'(pwr.fault_rail), 32'h1);
        pwr.enable = 1'b0;
        pwr.pg     = '0;
        wait_state("to cooldown", 3'd0, 40, w);
        chk("to cooldown latency", 32'(w), 32'(COOLDOWN + 1));
        chk("to fault cleared", 32'(pwr.fault), 32'h0);

        // 4: brownout on rails 0 and 2 while running
        tick(2);
        pwr.enable = 1'b1;
        ramp("bo", NR);
        wait_state("bo run", 3'd3, 40, w);
        pwr.pg = 3'b010;
        tick(2);
        chk("bo en before 3rd edge", 32'(pwr.en), 32'h7);
        tick(1);
        chk("bo en on 3rd edge", 32'(pwr.en), 32'h0);
        chk("bo state", 32'(pwr.state), 32'd6);
        chk("bo fault_rail", 32'(pwr.fault_rail), 32'h0);
        pwr.pg     = 3'b111;
        pwr.enable = 1'b0;
        wait_state("bo cooldown", 3'd0, 40, w);
        chk("bo cooldown latency", 32'(w), 32'(COOLDOWN + 1));
        pwr.pg = '0;

        // 5: rail 2 stuck low -> retries (if built) then lockout
        tick(2);
        pwr.enable = 1'b1;
        for (int a = 0; a < ATTEMPTS; a++) begin
            ramp($sformatf("rt%0d", a), 2);
            wait_state($sformatf("rt%0d fault", a), 3'd6, 80, w);
            chk($sformatf("rt%0d fault_rail", a), 32'(pwr.fault_rail), 32'h2);
            pwr.pg = '0;
        end
        wait_state("rt lockout", 3'd7, 40, w);
        chk("rt lockout latency", 32'(w), 32'(COOLDOWN + 1));
        chk("rt lockout en", 32'(pwr.en), 32'h0);
        chk("rt lockout fault", 32'(pwr.fault), 32'h1);
        pwr.enable = 1'b0;
        tick(1);
        chk("rt exit state", 32'(pwr.state), 32'd0);
        chk("rt exit fault", 32'(pwr.fault), 32'h0);

        // 6: reset asserted mid-ramp
        tick(2);
        pwr.enable = 1'b1;
        ramp("rs", 1);
        wait_en("rs rail1 on", 3'b011, 40, w);
        #2;
        reset_INV = 1'b0;
        #1;
        chk("rs en async", 32'(pwr.en), 32'h0);
        chk("rs state", 32'(pwr.state), 32'd0);
        chk("rs all_good", 32'(pwr.all_good), 32'h0);
        chk("rs fault", 32'(pwr.fault), 32'h0);
        chk("rs fault_rail", 32'(pwr.fault_rail), 32'h0);
        pwr.enable = 1'b0;
        pwr.pg     = '0;
        tick(1);
        reset_INV = 1'b1;
        tick(2);
        chk("rs idle after release", 32'(pwr.state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
